// File: rtl/cpc_bus_pkg.sv
// rtl/cpc_bus_pkg.sv - shared types and constants for the CPC expansion bus initiator
package cpc_bus_pkg;

    typedef enum logic [1:0] {
        OP_MEMRD = 2'd0,
        OP_MEMWR = 2'd1,
        OP_IORD  = 2'd2,
        OP_IOWR  = 2'd3
    } cpc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TWA  = 3'd3,
        ST_TW   = 3'd4,
        ST_T3   = 3'd5
    } cpc_state_e;

    // RAM expansion banking port: I/O write with A15=0, data D7:6 = 11
    localparam logic [15:0] RAM_CFG_IO_ADDR = 16'h7F00;
    localparam logic [1:0]  RAM_CFG_PREFIX  = 2'b11;

    localparam logic [15:0] MEM_WIN0_BASE = 16'h0000;
    localparam logic [15:0] MEM_WIN1_BASE = 16'h4000;
    localparam logic [15:0] MEM_WIN2_BASE = 16'h8000;
    localparam logic [15:0] MEM_WIN3_BASE = 16'hC000;

    function automatic logic op_is_io(input cpc_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_write(input cpc_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/cpc_bus_wait_timer.sv
// rtl/cpc_bus_wait_timer.sv - READY-low cycle counter with clear, enable and expiry
module cpc_bus_wait_timer #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] count_q;

    // Expires on the enabled cycle that would bring the count to MAX_WAIT
    assign expire_o = enable_i && (count_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/cpc_bus_initiator.sv
// rtl/cpc_bus_initiator.sv - Z80-style memory/I/O cycle initiator for the CPC expansion connector
module cpc_bus_initiator
    import cpc_bus_pkg::*;
#(
    parameter int IO_AUTO_WAIT = 1,
    parameter int MAX_WAIT     = 255,
    parameter int WAIT_W       = 8
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_ramdis,
    output logic        rsp_timeout,
    output logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        MREQ_B,
    output logic        IOREQ_B,
    output logic        RD_B,
    output logic        WR_B,
    output logic        M1_B,
    output logic        RFSH_B,
    input  logic        READY,
    input  logic        RAMDIS
);

    localparam logic [1:0] AW_LAST = 2'(IO_AUTO_WAIT);

    cpc_state_e  state_q, state_d;
    cpc_op_e     op_q;
    logic [1:0]  aw_q, aw_d;
    logic        accept, done, abort;
    logic        tmr_clr, tmr_en, tmr_expire;
    logic        bus_on_d;

    logic        cmd_ready_q, rsp_valid_q, rsp_ramdis_q, rsp_timeout_q;
    logic [7:0]  rsp_rdata_q, d_out_q;
    logic [15:0] a_q;
    logic        d_oe_q, mreq_b_q, iorq_b_q, rd_b_q, wr_b_q;

    cpc_bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk_i    (CLK),
        .rst_ni   (RESET_B),
        .clear_i  (tmr_clr),
        .enable_i (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        aw_d    = aw_q;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                tmr_clr = 1'b1;
                aw_d    = '0;
                state_d = ST_T2;
            end
            ST_T2: begin
                if (op_is_io(op_q) && (IO_AUTO_WAIT != 0)) begin
                    aw_d    = 2'd1;
                    state_d = ST_TWA;
                end else begin
                    state_d = READY ? ST_T3 : ST_TW;
                end
            end
            ST_TWA: begin
                if (aw_q == AW_LAST) begin
                    state_d = READY ? ST_T3 : ST_TW;
                end else begin
                    aw_d = aw_q + 2'd1;
                end
            end
            ST_TW: begin
                if (READY) begin
                    state_d = ST_T3;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        abort   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_T3: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    assign bus_on_d = (state_d == ST_T2) || (state_d == ST_TWA) ||
                      (state_d == ST_TW) || (state_d == ST_T3);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_MEMRD;
            aw_q          <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_ramdis_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            a_q           <= '0;
            d_out_q       <= '0;
            d_oe_q        <= 1'b0;
            mreq_b_q      <= 1'b1;
            iorq_b_q      <= 1'b1;
            rd_b_q        <= 1'b1;
            wr_b_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            aw_q        <= aw_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= done || abort;
            mreq_b_q    <= !(bus_on_d && !op_is_io(op_q));
            iorq_b_q    <= !(bus_on_d &&  op_is_io(op_q));
            rd_b_q      <= !(bus_on_d && !op_is_write(op_q));
            wr_b_q      <= !(bus_on_d &&  op_is_write(op_q));
            if (accept) begin
                op_q    <= cpc_op_e'(cmd_op);
                a_q     <= cmd_addr;
                d_out_q <= op_is_write(cpc_op_e'(cmd_op)) ? cmd_wdata : 8'h00;
                d_oe_q  <= op_is_write(cpc_op_e'(cmd_op));
            end
            if (done || abort) begin
                d_oe_q <= 1'b0;
            end
            if (done) begin
                rsp_rdata_q   <= op_is_write(op_q) ? 8'h00 : D_in;
                rsp_ramdis_q  <= op_is_io(op_q) ? 1'b0 : RAMDIS;
                rsp_timeout_q <= 1'b0;
            end else if (abort) begin
                rsp_rdata_q   <= 8'h00;
                rsp_ramdis_q  <= 1'b0;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_ramdis  = rsp_ramdis_q;
    assign rsp_timeout = rsp_timeout_q;
    assign A           = a_q;
    assign D_out       = d_out_q;
    assign D_oe        = d_oe_q;
    assign MREQ_B      = mreq_b_q;
    assign IOREQ_B     = iorq_b_q;
    assign RD_B        = rd_b_q;
    assign WR_B        = wr_b_q;
    assign M1_B        = 1'b1;
    assign RFSH_B      = 1'b1;

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// tb/tb_cpc_bus_initiator.sv - randomized self-checking bench for cpc_bus_initiator
module tb_cpc_bus_initiator;
    import cpc_bus_pkg::*;

    localparam int IOAW = 1;
    localparam int MAXW = 4;

    logic        CLK = 1'b0;
    logic        RESET_B = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_addr = 16'h0;
    logic [7:0]  cmd_wdata = 8'h0;
    logic        rsp_valid, rsp_ramdis, rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic [15:0] A;
    logic [7:0]  D_in = 8'h0;
    logic [7:0]  D_out;
    logic        D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;
    logic        READY = 1'b1;
    logic        RAMDIS = 1'b0;

    cpc_bus_initiator #(
        .IO_AUTO_WAIT (IOAW),
        .MAX_WAIT     (MAXW),
        .WAIT_W       (8)
    ) dut (
        .CLK         (CLK),
        .RESET_B     (RESET_B),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_ramdis  (rsp_ramdis),
        .rsp_timeout (rsp_timeout),
        .A           (A),
        .D_in        (D_in),
        .D_out       (D_out),
        .D_oe        (D_oe),
        .MREQ_B      (MREQ_B),
        .IOREQ_B     (IOREQ_B),
        .RD_B        (RD_B),
        .WR_B        (WR_B),
        .M1_B        (M1_B),
        .RFSH_B      (RFSH_B),
        .READY       (READY),
        .RAMDIS      (RAMDIS)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          nw;
        logic [7:0]  rdval;
        logic        ramdis;
    } txn_t;

    txn_t txns[$];
    bit   chain[$];

    function automatic txn_t mk(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wdata,
                                input int nw, input logic [7:0] rdval, input logic ramdis);
        txn_t t;
        t.op = op; t.addr = addr; t.wdata = wdata; t.nw = nw; t.rdval = rdval; t.ramdis = ramdis;
        return t;
    endfunction

    task automatic present(input txn_t t);
        cmd_op    = t.op;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_valid = 1'b1;
    endtask

    // Model: the strobes stay low for T2 + auto waits + one clock per READY-low sample + T3,
    // or for T2 + auto waits + MAXW wait clocks when READY stays low past the limit.
    task automatic run_txn(input txn_t t, input bit chained_in, input bit chain_out, input txn_t nxt);
        int waits = 0, low = 0, oe = 0, busy = 0, rsp_t = 0, pat_err = 0, ad_err = 0;
        int aw, exp_low;
        bit is_io, is_wr, tmo;
        logic [5:0] exp_pat;
        logic [7:0] exp_rd;
        is_io   = t.op[1];
        is_wr   = t.op[0];
        aw      = is_io ? IOAW : 0;
        tmo     = (t.nw > MAXW);
        exp_low = tmo ? (1 + aw + MAXW) : (2 + aw + t.nw);
        exp_pat = {is_io, !is_io, is_wr, !is_wr, 2'b11};
        exp_rd  = (tmo || is_wr) ? 8'h00 : t.rdval;
        present(t);
        READY = 1'b1;
        while (!cmd_ready && waits < 50) begin
            @(negedge CLK);
            waits++;
        end
        if (chained_in) check_eq("b2b_idle_gap", waits, 0);
        @(negedge CLK);
        if (chain_out) present(nxt);
        else begin
            cmd_valid = 1'b0;
            cmd_addr  = 16'($urandom);
        end
        for (int tk = 1; tk <= 60; tk++) begin
            if ({MREQ_B, IOREQ_B, RD_B, WR_B} != 4'hF) begin
                low++;
                if ({MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B} !== exp_pat) pat_err++;
                READY = !(low >= 1 + aw && low < 1 + aw + t.nw);
                if (low == 2 + aw + t.nw) begin
                    D_in   = t.rdval;
                    RAMDIS = t.ramdis;
                end else begin
                    D_in   = 8'($urandom);
                    RAMDIS = !t.ramdis;
                end
            end else begin
                READY  = 1'b1;
                D_in   = 8'($urandom);
                RAMDIS = !t.ramdis;
            end
            if (!rsp_valid) begin
                if (A !== t.addr) ad_err++;
                if (is_wr && D_out !== t.wdata) ad_err++;
            end
            if (D_oe) oe++;
            if (!cmd_ready) busy++;
            if (rsp_valid) begin
                rsp_t = tk;
                break;
            end
            @(negedge CLK);
        end
        check_eq("rsp_latency", rsp_t, exp_low + 2);
        check_eq("strobe_low_clocks", low, exp_low);
        check_eq("strobe_pattern_errs", pat_err, 0);
        check_eq("addr_data_errs", ad_err, 0);
        check_eq("d_oe_clocks", oe, is_wr ? exp_low + 1 : 0);
        check_eq("cmd_ready_low_clocks", busy, exp_low + 1);
        check_eq("idle_strobes", {MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B}, 6'h3F);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_ramdis", rsp_ramdis, (tmo || is_io) ? 1'b0 : t.ramdis);
        check_eq("rsp_timeout", rsp_timeout, tmo);
        if (!chain_out) begin
            @(negedge CLK);
            check_eq("rsp_pulse_width", rsp_valid, 1'b0);
            check_eq("rsp_hold", {rsp_timeout, rsp_rdata}, {tmo, exp_rd});
        end
    endtask

    task automatic run_all();
        for (int i = 0; i < txns.size(); i++) begin
            run_txn(txns[i], (i > 0) && chain[i-1], chain[i], (i + 1 < txns.size()) ? txns[i+1] : txns[i]);
        end
        txns.delete();
        chain.delete();
    endtask

    initial begin
        logic [15:0] bases [4];
        int lowc;
        bases[0] = MEM_WIN0_BASE; bases[1] = MEM_WIN1_BASE;
        bases[2] = MEM_WIN2_BASE; bases[3] = MEM_WIN3_BASE;

        repeat (3) @(negedge CLK);
        check_eq("reset_strobes", {MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B}, 6'h3F);
        check_eq("reset_bus", {A, D_out, D_oe}, 25'h0);
        check_eq("reset_rsp", {rsp_valid, rsp_rdata, rsp_ramdis, rsp_timeout}, 11'h0);
        check_eq("reset_cmd_ready", cmd_ready, 1'b0);
        RESET_B = 1'b1;
        @(negedge CLK);
        check_eq("ready_after_reset", cmd_ready, 1'b1);

        txns.push_back(mk(OP_IOWR, RAM_CFG_IO_ADDR, 8'hC4, 0, 8'h00, 1'b0)); chain.push_back(0);
        txns.push_back(mk(OP_MEMRD, MEM_WIN1_BASE, 8'h00, 0, 8'h5A, 1'b1)); chain.push_back(0);
        txns.push_back(mk(OP_MEMWR, MEM_WIN3_BASE, 8'h33, 3, 8'h00, 1'b0)); chain.push_back(0);
        txns.push_back(mk(OP_MEMRD, MEM_WIN2_BASE, 8'h00, 9, 8'hA5, 1'b1)); chain.push_back(0);
        txns.push_back(mk(OP_MEMRD, 16'h8123, 8'h00, 0, 8'h11, 1'b0)); chain.push_back(0);
        txns.push_back(mk(OP_MEMRD, 16'h0001, 8'h00, 0, 8'h21, 1'b1)); chain.push_back(1);
        txns.push_back(mk(OP_MEMRD, 16'h0002, 8'h00, 1, 8'h42, 1'b0)); chain.push_back(1);
        txns.push_back(mk(OP_MEMRD, 16'h0003, 8'h00, 0, 8'h84, 1'b1)); chain.push_back(0);
        run_all();

        // Reset pulsed while an I/O read sits in wait states
        present(mk(OP_IORD, RAM_CFG_IO_ADDR, 8'h00, 20, 8'h00, 1'b0));
        READY = 1'b0;
        lowc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if ({MREQ_B, IOREQ_B, RD_B, WR_B} != 4'hF) lowc++;
            if (lowc == 3) break;
        end
        check_eq("rst_reach_tw", lowc, 3);
        cmd_valid = 1'b0;
        #2 RESET_B = 1'b0;
        #1;
        check_eq("rst_async_strobes", {MREQ_B, IOREQ_B, RD_B, WR_B}, 4'hF);
        check_eq("rst_no_rsp", rsp_valid, 1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge CLK);
        RESET_B = 1'b1;
        READY = 1'b1;
        check_eq("rst_no_rsp_2", rsp_valid, 1'b0);
        @(negedge CLK);
        check_eq("rst_release_ready", cmd_ready, 1'b1);
        check_eq("rst_release_no_rsp", rsp_valid, 1'b0);

        for (int i = 0; i < 50; i++) begin
            logic [1:0]  op;
            logic [15:0] addr;
            logic [7:0]  wd;
            op = 2'($urandom_range(0, 3));
            if (op[1] && $urandom_range(0, 1) == 1) addr = RAM_CFG_IO_ADDR;
            else addr = bases[$urandom_range(0, 3)] | 16'($urandom_range(0, 16'h3FFF));
            wd = (addr == RAM_CFG_IO_ADDR) ? {RAM_CFG_PREFIX, 6'($urandom)} : 8'($urandom);
            txns.push_back(mk(op, addr, wd, $urandom_range(0, 6), 8'($urandom), 1'($urandom)));
            chain.push_back((i < 49) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        run_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
